// File: rtl/bcd_seg_scan_if.sv
// bcd_seg_scan_if: BCD value strobe, display enable and multiplexed segment/digit outputs
interface bcd_seg_scan_if;
  logic [15:0] DEC_data;
  logic        HEX2DEC_completed;
  logic        disp_en;
  logic [7:0]  seg;
  logic [3:0]  sel;
  modport master (output DEC_data, HEX2DEC_completed, disp_en, input seg, sel);
  modport slave  (input DEC_data, HEX2DEC_completed, disp_en, output seg, sel);
endinterface

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: latches a four-digit BCD value and time-multiplexes it onto a
// common-anode 7-segment display with optional leading-zero blanking
module bcd_seg_scan #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1
) (
  input logic           clk_50m,
  input logic           rst_n,
  bcd_seg_scan_if.slave bus
);
  localparam logic [15:0] DIV_MAX = 16'(SCAN_DIV - 1);
  logic [15:0] div_cnt;
  logic [15:0] disp_reg;
  logic [1:0]  idx;
  logic [3:0]  nib;
  logic [3:0]  zero_up;
  logic        wrap;
  logic        blank;
  logic [7:0]  seg_nxt;
  logic [3:0]  sel_nxt;
  function automatic logic [7:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 8'hC0;
      4'd1:    enc = 8'hF9;
      4'd2:    enc = 8'hA4;
      4'd3:    enc = 8'hB0;
      4'd4:    enc = 8'h99;
      4'd5:    enc = 8'h92;
      4'd6:    enc = 8'h82;
      4'd7:    enc = 8'hF8;
      4'd8:    enc = 8'h80;
      4'd9:    enc = 8'h90;
      default: enc = 8'hBF;
    endcase
  endfunction
  // zero_up[i] is set when digit i and every digit above it are zero
  always_comb begin
    wrap       = div_cnt == DIV_MAX;
    nib        = disp_reg[{idx, 2'b00} +: 4];
    zero_up[3] = disp_reg[15:12] == 4'd0;
    zero_up[2] = zero_up[3] && disp_reg[11:8] == 4'd0;
    zero_up[1] = zero_up[2] && disp_reg[7:4] == 4'd0;
    zero_up[0] = zero_up[1] && disp_reg[3:0] == 4'd0;
    blank      = BLANK_LZ && idx != 2'd0 && zero_up[idx];
    seg_nxt    = !bus.disp_en || blank ? 8'hFF : enc(nib);
    sel_nxt    = bus.disp_en ? ~(4'b0001 << idx) : 4'hF;
  end
  // divider and index keep running while disabled so scan phase is preserved
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      idx      <= '0;
      disp_reg <= '0;
      bus.seg  <= 8'hFF;
      bus.sel  <= 4'hF;
    end else begin
      div_cnt  <= wrap ? '0 : div_cnt + 16'd1;
      idx      <= wrap ? idx + 2'd1 : idx;
      disp_reg <= bus.HEX2DEC_completed ? bus.DEC_data : disp_reg;
      bus.seg  <= seg_nxt;
      bus.sel  <= sel_nxt;
    end
  end
endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: directed checks of scan order, encoding, blanking, disable and reset
module tb_bcd_seg_scan;
  logic clk_50m = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  bcd_seg_scan_if bus_a ();
  bcd_seg_scan_if bus_b ();
  assign bus_b.DEC_data          = bus_a.DEC_data;
  assign bus_b.HEX2DEC_completed = bus_a.HEX2DEC_completed;
  assign bus_b.disp_en           = bus_a.disp_en;
  bcd_seg_scan #(.SCAN_DIV(4), .BLANK_LZ(1)) dut_a (.clk_50m(clk_50m), .rst_n(rst_n), .bus(bus_a));
  bcd_seg_scan #(.SCAN_DIV(4), .BLANK_LZ(0)) dut_b (.clk_50m(clk_50m), .rst_n(rst_n), .bus(bus_b));
  always #10 clk_50m = ~clk_50m;

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  function automatic logic [3:0] sel_of(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << i);
  endfunction

  // reset, release, then strobe d into the display register on the first edge
  task automatic start(input logic [15:0] d);
    rst_n = 1'b0;
    bus_a.HEX2DEC_completed = 1'b0;
    bus_a.disp_en = 1'b1;
    bus_a.DEC_data = 16'h0000;
    repeat (2) tick();
    rst_n = 1'b1;
    bus_a.DEC_data = d;
    bus_a.HEX2DEC_completed = 1'b1;
    tick();
    bus_a.HEX2DEC_completed = 1'b0;
  endtask

  task automatic test_reset();
    int i;
    logic [7:0] ea;
    rst_n = 1'b0;
    bus_a.disp_en = 1'b1;
    bus_a.HEX2DEC_completed = 1'b0;
    bus_a.DEC_data = 16'h5678;
    repeat (3) tick();
    checks++;
    if (bus_a.seg !== 8'hFF || bus_a.sel !== 4'hF) begin
      errors++;
      $display("FAIL reset_state sel=%b seg=%h expected sel=1111 seg=ff", bus_a.sel, bus_a.seg);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      i = ((k - 1) / 4) % 4;
      ea = i == 0 ? 8'hC0 : 8'hFF;
      checks++;
      if (bus_a.sel !== sel_of(i) || bus_a.seg !== ea) begin
        errors++;
        $display("FAIL reset_scan_a k=%0d sel=%b seg=%h expected sel=%b seg=%h", k, bus_a.sel, bus_a.seg, sel_of(i), ea);
      end
      checks++;
      if (bus_b.sel !== sel_of(i) || bus_b.seg !== 8'hC0) begin
        errors++;
        $display("FAIL reset_scan_b k=%0d sel=%b seg=%h expected sel=%b seg=c0", k, bus_b.sel, bus_b.seg, sel_of(i));
      end
    end
  endtask

  // ea/eb packed {thousands, hundreds, tens, ones} for BLANK_LZ=1 / BLANK_LZ=0
  task automatic test_digits(input logic [15:0] d, input logic [31:0] ea, input logic [31:0] eb, input string name);
    int i;
    start(d);
    for (int k = 2; k <= 17; k++) begin
      tick();
      i = ((k - 1) / 4) % 4;
      checks++;
      if (bus_a.sel !== sel_of(i) || bus_a.seg !== ea[8*i +: 8]) begin
        errors++;
        $display("FAIL %s_a k=%0d sel=%b seg=%h expected sel=%b seg=%h", name, k, bus_a.sel, bus_a.seg, sel_of(i), ea[8*i +: 8]);
      end
      checks++;
      if (bus_b.sel !== sel_of(i) || bus_b.seg !== eb[8*i +: 8]) begin
        errors++;
        $display("FAIL %s_b k=%0d sel=%b seg=%h expected sel=%b seg=%h", name, k, bus_b.sel, bus_b.seg, sel_of(i), eb[8*i +: 8]);
      end
    end
  endtask

  task automatic test_load_on_wrap();
    start(16'h0000);
    repeat (2) tick();
    bus_a.DEC_data = 16'h0070;
    bus_a.HEX2DEC_completed = 1'b1;
    tick();
    bus_a.HEX2DEC_completed = 1'b0;
    checks++;
    if (bus_a.sel !== 4'b1110 || bus_a.seg !== 8'hC0) begin
      errors++;
      $display("FAIL wrap_load_e4 sel=%b seg=%h expected sel=1110 seg=c0", bus_a.sel, bus_a.seg);
    end
    tick();
    checks++;
    if (bus_a.sel !== 4'b1101 || bus_a.seg !== 8'hF8) begin
      errors++;
      $display("FAIL wrap_load_e5 sel=%b seg=%h expected sel=1101 seg=f8", bus_a.sel, bus_a.seg);
    end
    repeat (4) tick();
    checks++;
    if (bus_a.sel !== 4'b1011 || bus_a.seg !== 8'hFF) begin
      errors++;
      $display("FAIL wrap_load_e9a sel=%b seg=%h expected sel=1011 seg=ff", bus_a.sel, bus_a.seg);
    end
    checks++;
    if (bus_b.sel !== 4'b1011 || bus_b.seg !== 8'hC0) begin
      errors++;
      $display("FAIL wrap_load_e9b sel=%b seg=%h expected sel=1011 seg=c0", bus_b.sel, bus_b.seg);
    end
  endtask

  task automatic test_back_to_back();
    int i;
    logic [31:0] ea;
    ea = {8'hFF, 8'hBF, 8'h90, 8'hF8};
    start(16'h1234);
    bus_a.DEC_data = 16'h0405;
    bus_a.HEX2DEC_completed = 1'b1;
    tick();
    bus_a.DEC_data = 16'h0A97;
    tick();
    bus_a.HEX2DEC_completed = 1'b0;
    for (int k = 4; k <= 19; k++) begin
      tick();
      i = ((k - 1) / 4) % 4;
      checks++;
      if (bus_a.sel !== sel_of(i) || bus_a.seg !== ea[8*i +: 8]) begin
        errors++;
        $display("FAIL back_to_back k=%0d sel=%b seg=%h expected sel=%b seg=%h", k, bus_a.sel, bus_a.seg, sel_of(i), ea[8*i +: 8]);
      end
    end
  endtask

  task automatic test_disable();
    int i;
    logic [31:0] ea;
    logic [3:0] es;
    logic [7:0] eg;
    ea = {8'hF9, 8'hA4, 8'hB0, 8'h99};
    start(16'h1234);
    for (int k = 2; k <= 17; k++) begin
      bus_a.disp_en = (k >= 6 && k <= 11) ? 1'b0 : 1'b1;
      tick();
      i = ((k - 1) / 4) % 4;
      es = bus_a.disp_en ? sel_of(i) : 4'hF;
      eg = bus_a.disp_en ? ea[8*i +: 8] : 8'hFF;
      checks++;
      if (bus_a.sel !== es || bus_a.seg !== eg) begin
        errors++;
        $display("FAIL disable k=%0d sel=%b seg=%h expected sel=%b seg=%h", k, bus_a.sel, bus_a.seg, es, eg);
      end
    end
    bus_a.disp_en = 1'b1;
  endtask

  task automatic test_reset_collide();
    int i;
    logic [7:0] ea;
    start(16'h1234);
    repeat (5) tick();
    rst_n = 1'b0;
    bus_a.DEC_data = 16'h9999;
    bus_a.HEX2DEC_completed = 1'b1;
    tick();
    bus_a.HEX2DEC_completed = 1'b0;
    checks++;
    if (bus_a.seg !== 8'hFF || bus_a.sel !== 4'hF) begin
      errors++;
      $display("FAIL collide_reset sel=%b seg=%h expected sel=1111 seg=ff", bus_a.sel, bus_a.seg);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      i = ((k - 1) / 4) % 4;
      ea = i == 0 ? 8'hC0 : 8'hFF;
      checks++;
      if (bus_a.sel !== sel_of(i) || bus_a.seg !== ea) begin
        errors++;
        $display("FAIL collide_scan k=%0d sel=%b seg=%h expected sel=%b seg=%h", k, bus_a.sel, bus_a.seg, sel_of(i), ea);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.DEC_data = 16'h0000;
    bus_a.HEX2DEC_completed = 1'b0;
    bus_a.disp_en = 1'b1;
    test_reset();
    test_digits(16'h1234, {8'hF9, 8'hA4, 8'hB0, 8'h99}, {8'hF9, 8'hA4, 8'hB0, 8'h99}, "d1234");
    test_digits(16'h0405, {8'hFF, 8'h99, 8'hC0, 8'h92}, {8'hC0, 8'h99, 8'hC0, 8'h92}, "d0405");
    test_digits(16'h00A0, {8'hFF, 8'hFF, 8'hBF, 8'hC0}, {8'hC0, 8'hC0, 8'hBF, 8'hC0}, "d00a0");
    test_digits(16'h8006, {8'h80, 8'hC0, 8'hC0, 8'h82}, {8'h80, 8'hC0, 8'hC0, 8'h82}, "d8006");
    test_digits(16'h0FFF, {8'hFF, 8'hBF, 8'hBF, 8'hBF}, {8'hC0, 8'hBF, 8'hBF, 8'hBF}, "d0fff");
    test_load_on_wrap();
    test_back_to_back();
    test_disable();
    test_reset_collide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
